// File: rtl/prog_timeout_timer.sv
// Programmable timeout timer: a prescaler makes a base tick every TICK_DIV
// clocks and a down-counter times load_val ticks, in one-shot or periodic mode.
module prog_timeout_timer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             clear,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             timeout,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             tick_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ps_q      <= '0;
      rem_q     <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      rem_q     <= rem_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: clear beats start, start beats a coinciding tick
  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    rem_d     = rem_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    timeout_d = 1'b0;
    tick_c    = (state_q == ST_RUN) && enable && (ps_q == PS_LAST);

    if (clear) begin
      state_d   = ST_IDLE;
      ps_d      = '0;
      rem_d     = '0;
      expired_d = 1'b0;
    end else if (start && (load_val != '0)) begin
      state_d   = ST_RUN;
      ps_d      = '0;
      rem_d     = load_val;
      reload_d  = load_val;
      mode_d    = periodic;
      expired_d = 1'b0;
    end else if ((state_q == ST_RUN) && enable) begin
      if (tick_c) begin
        ps_d = '0;
        if (rem_q > CNT_W'(1)) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          timeout_d = 1'b1;
          if (mode_q) begin
            rem_d = reload_q;
          end else begin
            state_d   = ST_DONE;
            rem_d     = '0;
            expired_d = 1'b1;
          end
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  assign timeout   = timeout_q;
  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

endmodule

// File: doc/prog_timeout_timer.md
Name: prog_timeout_timer

Overview:
Parametrised millisecond-granularity timeout timer, the successor to the fixed 100 ms timer. An internal prescaler produces a base tick every TICK_DIV clocks; a down-counter counts a run-time-loadable number of ticks. Adds one-shot/periodic modes, pause via enable, restart, synchronous clear, sticky expiry flag and remaining-count visibility. Used by protocol/control FSMs needing arbitrary timeouts.

Parameters:
TICK_DIV, 50000, clocks per base tick (1 ms at 50 MHz); legal range >= 2
CNT_W, 16, width of tick count, load value and remaining count

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = timer advances; 0 = prescaler and count hold (pause)
start  input  1  single-cycle pulse: latch load_val and (re)start
clear  input  1  synchronous abort to IDLE, clears expired
periodic  input  1  sampled at start: 1 = auto-reload, 0 = one-shot
load_val  input  CNT_W  number of base ticks to time; sampled at start
timeout  output  1  one-cycle pulse at each expiry
expired  output  1  sticky, set on one-shot expiry
busy  output  1  high in RUN
remaining  output  CNT_W  ticks left in current period

Behaviour:
- Reset (rst=0, async): state IDLE, prescaler 0, remaining 0, reload reg 0, mode reg 0; timeout=0, expired=0, busy=0.
- States: IDLE, RUN, DONE. busy = (state==RUN).
- Prescaler: internal width $clog2(TICK_DIV). Counts only in RUN with enable=1; at TICK_DIV-1 wraps to 0 and raises internal tick for that cycle. Holds value when enable=0.
- start (any state, clear=0, load_val!=0): next edge -> RUN, prescaler 0, remaining=load_val, reload reg=load_val, mode reg=periodic, expired=0. Restart in RUN discards progress.
- start with load_val==0: ignored, no state/output change.
- clear: next edge -> IDLE, prescaler 0, remaining 0, expired 0, no timeout. clear wins over simultaneous start.
- RUN, tick with remaining>1: remaining decrements.
- RUN, tick with remaining==1: timeout=1 for exactly the next cycle (registered). One-shot: -> DONE, remaining 0, expired=1. Periodic: stay RUN, remaining=reload reg, prescaler continues from 0.
- Latency: with enable held high, timeout rises load_val*TICK_DIV cycles after the edge that samples start; periodic pulses repeat every load_val*TICK_DIV cycles. Each enable=0 cycle in RUN adds exactly one cycle.
- Tick and start coinciding: start wins, no timeout.
- DONE: holds until start or clear; expired stays 1; enable ignored.
- IDLE/DONE: enable has no effect; timeout never asserted.
- remaining never wraps below 0; no arithmetic overflow (load_val <= 2^CNT_W-1).

Test Plan:
(Bench uses TICK_DIV=4, CNT_W=8.)
- Reset then start, load_val=3, periodic=0, enable=1 -> timeout single pulse 12 cycles after start edge; expired=1, busy=0, remaining=0 afterwards.
- Periodic, load_val=2 -> timeout pulses at 8, 16, 24 cycles after start; busy stays 1; remaining sequence 2,1,2,1...
- One-shot load_val=3, enable=0 for 5 cycles mid-run -> timeout at 17 cycles; remaining frozen during pause.
- Start load_val=5, re-start with load_val=2 after 10 cycles -> no timeout at original 20; pulse 8 cycles after second start.
- clear and start same cycle during RUN -> IDLE, busy=0, expired=0, no timeout for 40 cycles; start with load_val=0 -> no change.
- Assert rst low mid-run (async, between edges) -> all outputs 0 immediately; after release, no timeout until a new start.
